// File: rtl/mul_radix4_seq.sv
// Iterative radix-4 multiplier: two multiplier bits per clock, WIDTH/2+1 cycles per product.
// Optional two's-complement mode is built only when MUL_SIGNED_EN is defined.
module mul_radix4_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  input  logic [WIDTH-1:0]     iA,
  input  logic [WIDTH-1:0]     iB,
  input  logic                 iSigned,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2*WIDTH-1:0]   oResult
);

  localparam int CW = $clog2(WIDTH/2);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(WIDTH/2 - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_mag_a;
  logic [WIDTH-1:0]     r_mag_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_result;

  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH+1:0]     w_partial;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_final;

`ifdef MUL_SIGNED_EN
  logic                 r_neg;
  logic                 w_neg;

  // -2^(WIDTH-1) maps onto 2^(WIDTH-1), which still fits the unsigned magnitude
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Operand magnitudes and result sign at start acceptance
  always_comb begin
    w_mag_a = magnitude(iA, iSigned);
    w_mag_b = magnitude(iB, iSigned);
    w_neg   = iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
  end

  // Sign restoration of the accumulated magnitude product
  always_comb begin
    if (r_neg) begin
      w_final = ~r_acc + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_final = r_acc;
    end
  end
`else
  logic                 w_unused_signed;
  assign w_unused_signed = iSigned;

  // Unsigned build: raw operands, no negation
  always_comb begin
    w_mag_a = iA;
    w_mag_b = iB;
    w_final = r_acc;
  end
`endif

  // Radix-4 partial product of the current multiplier digit, aligned to its weight
  always_comb begin
    w_partial = {(WIDTH+2){1'b0}};
    case (r_mag_b[1:0])
      2'd0:    w_partial = {(WIDTH+2){1'b0}};
      2'd1:    w_partial = {2'b00, r_mag_a};
      2'd2:    w_partial = {1'b0, r_mag_a, 1'b0};
      2'd3:    w_partial = {1'b0, r_mag_a, 1'b0} + {2'b00, r_mag_a};
      default: w_partial = {(WIDTH+2){1'b0}};
    endcase
    w_addend = {{(WIDTH-2){1'b0}}, w_partial} << {r_cnt, 1'b0};
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
`ifdef MUL_SIGNED_EN
      r_neg    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (iStart) begin
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
`ifdef MUL_SIGNED_EN
            r_neg   <= w_neg;
`endif
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Multiplier shifts down so the live digit is always in bits [1:0]
          r_acc   <= r_acc + w_addend;
          r_mag_b <= r_mag_b >> 2;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST_DIGIT) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_result <= w_final;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign oBusy   = r_busy;
  assign oDone   = r_done;
  assign oResult = r_result;

endmodule

// File: tb/tb_mul_radix4_seq.sv
// Self-checking bench for mul_radix4_seq (WIDTH=16 and WIDTH=8 instances) against an
// arithmetic reference product; honours MUL_SIGNED_EN the same way as the design.
module tb_mul_radix4_seq;

`ifdef MUL_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic        Clock;
  logic        Reset;
  logic        iStart;
  logic        iSigned;
  logic [15:0] iA;
  logic [15:0] iB;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oResult;

  logic        start8;
  logic        signed8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] res8;

  int n_total = 0;
  int n_bad   = 0;

  mul_radix4_seq #(.WIDTH(16)) dut16 (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iA(iA), .iB(iB),
    .iSigned(iSigned), .oBusy(oBusy), .oDone(oDone), .oResult(oResult)
  );

  mul_radix4_seq #(.WIDTH(8)) dut8 (
    .Clock(Clock), .Reset(Reset), .iStart(start8), .iA(a8), .iB(b8),
    .iSigned(signed8), .oBusy(busy8), .oDone(done8), .oResult(res8)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Exact w-bit x w-bit product, interpreted as two's complement when s applies
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input int w, input bit s);
    longint sa;
    longint sb;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'(a & mask);
    sb = longint'(b & mask);
    if (s && SIGNED_BUILD) begin
      if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
      if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
    end
    return 64'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Start one 16-bit multiply; optionally re-pulse iStart (9x9) at edge E<repulse>
  task automatic mul16(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input int repulse, input logic [31:0] exp, input string tag);
    int cyc;
    bit busy_ok;
    iA = a; iB = b; iSigned = s; iStart = 1'b1;
    @(posedge Clock); #1;
    iStart = 1'b0;
    iA = 16'($urandom); iB = 16'($urandom); iSigned = 1'($urandom);
    cyc = 0;
    busy_ok = 1'b1;
    while (!oDone && cyc < 40) begin
      if (!oBusy) busy_ok = 1'b0;
      if (repulse > 0 && cyc == repulse - 1) begin
        iStart = 1'b1; iA = 16'd9; iB = 16'd9;
      end
      @(posedge Clock); #1;
      iStart = 1'b0;
      cyc++;
    end
    check_val({tag, "_lat"}, 64'(cyc), 64'd9);
    check_val({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    check_val({tag, "_busy_done"}, 64'(oBusy), 64'd0);
    check_val({tag, "_res"}, 64'(oResult), 64'(exp));
  endtask

  task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] exp, input string tag);
    int cyc;
    a8 = a; b8 = b; signed8 = s; start8 = 1'b1;
    @(posedge Clock); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    cyc = 0;
    while (!done8 && cyc < 40) begin
      @(posedge Clock); #1;
      cyc++;
    end
    check_val({tag, "_lat"}, 64'(cyc), 64'd5);
    check_val({tag, "_res"}, 64'(res8), 64'(exp));
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    logic [7:0]  ra8;
    logic [7:0]  rb8;

    Reset = 1'b0; iStart = 1'b0; iA = '0; iB = '0; iSigned = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; signed8 = 1'b0;
    #12;
    check_val("rst_res", 64'(oResult), 64'd0);
    check_val("rst_busy", 64'(oBusy), 64'd0);
    check_val("rst_done", 64'(oDone), 64'd0);
    check_val("rst_res8", 64'(res8), 64'd0);
    Reset = 1'b1;
    @(posedge Clock); #1;

    mul16(16'hFFFF, 16'hFFFF, 1'b0, 0, 32'hFFFE0001, "max_u");
    mul16(16'hFFFD, 16'h0005, 1'b1, 0, SIGNED_BUILD ? 32'hFFFFFFF1 : 32'h0004FFF1, "neg3x5");
    mul16(16'h8000, 16'h8000, 1'b1, 0, 32'h40000000, "minxmin");
    mul16(16'h0003, 16'h0007, 1'b0, 4, 32'h00000015, "repulse");
    // Called while oDone is still high: exercises back-to-back acceptance
    mul16(16'h000C, 16'h000C, 1'b0, 0, 32'h00000090, "b2b");
    @(posedge Clock); #1;
    check_val("pulse_drop", 64'(oDone), 64'd0);
    check_val("idle_busy", 64'(oBusy), 64'd0);
    check_val("held_res", 64'(oResult), 64'h90);

    mul16(16'h0000, 16'h1234, 1'b0, 0, 32'h0, "zero");
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      mul16(ra, rb, rs, 0, 32'(ref_mul(64'(ra), 64'(rb), 16, rs)), "rand16");
    end
    mul16(16'h8000, 16'h7FFF, 1'b1, 0, 32'(ref_mul(64'h8000, 64'h7FFF, 16, 1'b1)), "minxmax");

    // Asynchronous reset between E4 and E5 of an in-flight multiply
    iA = 16'h1234; iB = 16'h5678; iSigned = 1'b0; iStart = 1'b1;
    @(posedge Clock); #1;
    iStart = 1'b0;
    repeat (4) @(posedge Clock);
    #3;
    Reset = 1'b0;
    #1;
    check_val("arst_res", 64'(oResult), 64'd0);
    check_val("arst_busy", 64'(oBusy), 64'd0);
    check_val("arst_done", 64'(oDone), 64'd0);
    #2;
    Reset = 1'b1;
    mul16(16'h0002, 16'h0003, 1'b0, 0, 32'h00000006, "post_rst");

    mul8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "max8");
    for (int i = 0; i < 6; i++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom); rs = 1'($urandom);
      mul8(ra8, rb8, rs, 16'(ref_mul(64'(ra8), 64'(rb8), 8, rs)), "rand8");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
